mrr_tx_slot_arbiter: RTL and testbench

Shares the single backscatter/loopback transmitter between the NUM_PATHWAYS decode pathways. Each loopback unit raises a transmit request with a duration. The arbiter grants one pathway at a time in round-robin order and drives the combined tx_en_out. After every slot it enforces a programmable guard (recharge) gap. It replaces the plain OR of per-pathway tx_en at the decode-pathway top level.

---
 rtl/mrr_tx_slot_arbiter_pkg.sv | 14 +
 rtl/mrr_tx_slot_arbiter_rr_pick.sv | 29 ++
 rtl/mrr_tx_slot_arbiter.sv | 155 +++++++++++++++
 tb/tb_mrr_tx_slot_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrr_tx_slot_arbiter_pkg.sv
// Shared types and constants for the decode-pathway transmit slot arbiter.
package mrr_tx_slot_arbiter_pkg;

    // Number of decode pathways sharing the transmitter at the top level.
    localparam int unsigned NUM_DECODE_PATHWAYS = 4;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSlot  = 2'd1,
        StGuard = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mrr_tx_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mrr_tx_slot_arbiter_rr_pick #(
    parameter int unsigned NUM_PATHWAYS = 4,
    parameter int unsigned IDX_WIDTH    = 2
) (
    input  logic [NUM_PATHWAYS-1:0] req,
    input  logic [IDX_WIDTH-1:0]    ptr,
    output logic [IDX_WIDTH-1:0]    idx,
    output logic                    valid
);

    localparam int N = int'(NUM_PATHWAYS);

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        int j;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx   = IDX_WIDTH'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mrr_tx_slot_arbiter.sv
// Round-robin arbiter granting the shared backscatter transmitter to one decode
// pathway at a time, with a programmable guard gap after every slot.
module mrr_tx_slot_arbiter
    import mrr_tx_slot_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PATHWAYS = NUM_DECODE_PATHWAYS,
    parameter int unsigned IDX_WIDTH    = 2,
    parameter int unsigned LEN_WIDTH    = 20,
    parameter int unsigned GUARD_WIDTH  = 16,
    parameter int unsigned DIAG_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tx_disable,
    input  logic [GUARD_WIDTH-1:0]            guard_len,
    input  logic [NUM_PATHWAYS-1:0]           req,
    input  logic [LEN_WIDTH*NUM_PATHWAYS-1:0] req_len,
    output logic [NUM_PATHWAYS-1:0]           grant,
    output logic [NUM_PATHWAYS-1:0]           done,
    output logic                              done_aborted,
    output logic                              tx_en_out,
    output logic                              busy,
    output logic [IDX_WIDTH-1:0]              active_idx,
    input  logic                              reset_diagnostic_counter,
    output logic [DIAG_WIDTH-1:0]             grant_count,
    output logic [DIAG_WIDTH-1:0]             abort_count
);

    arb_state_e               state_q;
    logic [LEN_WIDTH-1:0]     len_cnt_q;
    logic [GUARD_WIDTH-1:0]   guard_cnt_q;
    logic [IDX_WIDTH-1:0]     rr_ptr_q;
    logic [IDX_WIDTH-1:0]     active_idx_q;
    logic [NUM_PATHWAYS-1:0]  grant_q;
    logic [NUM_PATHWAYS-1:0]  done_q;
    logic                     done_aborted_q;
    logic                     tx_en_q;
    logic [DIAG_WIDTH-1:0]    grant_count_q;
    logic [DIAG_WIDTH-1:0]    abort_count_q;

    logic [IDX_WIDTH-1:0]     pick_idx;
    logic                     pick_valid;
    logic [LEN_WIDTH-1:0]     pick_len;
    logic [IDX_WIDTH-1:0]     rr_next;
    logic                     start;
    logic                     slot_abort;
    logic                     slot_release;
    logic                     slot_last;
    logic                     slot_end;

    mrr_tx_slot_arbiter_rr_pick #(
        .NUM_PATHWAYS (NUM_PATHWAYS),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Grant decision and slot termination conditions; abort outranks release.
    always_comb begin
        pick_len     = req_len[LEN_WIDTH*pick_idx +: LEN_WIDTH];
        rr_next      = (pick_idx == IDX_WIDTH'(NUM_PATHWAYS - 1)) ? '0
                                                                  : pick_idx + IDX_WIDTH'(1);
        start        = (state_q == StIdle) && !tx_disable && pick_valid;
        slot_abort   = (state_q == StSlot) && tx_disable;
        slot_release = (state_q == StSlot) && !req[active_idx_q];
        slot_last    = (state_q == StSlot) && (len_cnt_q == LEN_WIDTH'(1));
        slot_end     = slot_abort || slot_release || slot_last;
    end

    // Arbiter FSM with registered grant, tx enable and done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            len_cnt_q      <= '0;
            guard_cnt_q    <= '0;
            rr_ptr_q       <= '0;
            active_idx_q   <= '0;
            grant_q        <= '0;
            done_q         <= '0;
            done_aborted_q <= 1'b0;
            tx_en_q        <= 1'b0;
        end else begin
            done_q         <= '0;
            done_aborted_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StSlot;
                        active_idx_q <= pick_idx;
                        rr_ptr_q     <= rr_next;
                        // A zero length still gets one transmit cycle.
                        len_cnt_q    <= (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
                        grant_q      <= NUM_PATHWAYS'(1) << pick_idx;
                        tx_en_q      <= 1'b1;
                    end
                end
                StSlot: begin
                    if (slot_end) begin
                        grant_q        <= '0;
                        tx_en_q        <= 1'b0;
                        done_q         <= NUM_PATHWAYS'(1) << active_idx_q;
                        done_aborted_q <= slot_abort;
                        if (guard_len == '0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q     <= StGuard;
                            guard_cnt_q <= guard_len;
                        end
                    end else begin
                        len_cnt_q <= len_cnt_q - LEN_WIDTH'(1);
                    end
                end
                StGuard: begin
                    if (guard_cnt_q == GUARD_WIDTH'(1)) begin
                        state_q <= StIdle;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - GUARD_WIDTH'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Saturating diagnostic counters; the clear request beats any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_count_q <= '0;
            abort_count_q <= '0;
        end else if (reset_diagnostic_counter) begin
            grant_count_q <= '0;
            abort_count_q <= '0;
        end else begin
            if (start && (grant_count_q != '1)) begin
                grant_count_q <= grant_count_q + DIAG_WIDTH'(1);
            end
            if (slot_abort && (abort_count_q != '1)) begin
                abort_count_q <= abort_count_q + DIAG_WIDTH'(1);
            end
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign done_aborted = done_aborted_q;
    assign tx_en_out    = tx_en_q;
    assign busy         = (state_q != StIdle);
    assign active_idx   = active_idx_q;
    assign grant_count  = grant_count_q;
    assign abort_count  = abort_count_q;

endmodule

// File: tb/tb_mrr_tx_slot_arbiter.sv
// Directed bench for mrr_tx_slot_arbiter with hand-computed expectations.
module tb_mrr_tx_slot_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned LW = 20;
    localparam int unsigned GW = 16;
    // Narrow diagnostic counters so saturation is reachable in a short run.
    localparam int unsigned DW = 4;

    logic            clk;
    logic            rst;
    logic            tx_disable;
    logic [GW-1:0]   guard_len;
    logic [NP-1:0]   req;
    logic [LW*NP-1:0] req_len;
    logic [NP-1:0]   grant;
    logic [NP-1:0]   done;
    logic            done_aborted;
    logic            tx_en_out;
    logic            busy;
    logic [1:0]      active_idx;
    logic            reset_diagnostic_counter;
    logic [DW-1:0]   grant_count;
    logic [DW-1:0]   abort_count;

    int n_checks;
    int n_errors;

    mrr_tx_slot_arbiter #(
        .NUM_PATHWAYS (NP),
        .IDX_WIDTH    (2),
        .LEN_WIDTH    (LW),
        .GUARD_WIDTH  (GW),
        .DIAG_WIDTH   (DW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .tx_disable               (tx_disable),
        .guard_len                (guard_len),
        .req                      (req),
        .req_len                  (req_len),
        .grant                    (grant),
        .done                     (done),
        .done_aborted             (done_aborted),
        .tx_en_out                (tx_en_out),
        .busy                     (busy),
        .active_idx               (active_idx),
        .reset_diagnostic_counter (reset_diagnostic_counter),
        .grant_count              (grant_count),
        .abort_count              (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [LW-1:0] v);
        req_len[LW*i +: LW] = v;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) step(1);
        check("idle_reached", busy, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        logic [NP-1:0] order [3];
        logic [NP-1:0] seen;
        int gap;
        int s;
        int ph;

        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b1000;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        tx_disable = 1'b0;
        guard_len = '0;
        req = 4'b1111;
        req_len = '0;
        reset_diagnostic_counter = 1'b0;
        for (int i = 0; i < 4; i++) set_len(i, 10);

        // Reset holds everything at zero even with all requests up.
        step(3);
        check("rst_grant", grant, 0);
        check("rst_tx_en", tx_en_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gcount", grant_count, 0);
        check("rst_acount", abort_count, 0);
        check("rst_idx", active_idx, 0);
        rst = 1'b1;
        step(2);
        check("post_rst_grant", grant, 4'b0001);
        check("post_rst_tx_en", tx_en_out, 1);
        step(2);
        // Asynchronous reset mid-slot drops grant before any clock edge.
        rst = 1'b0;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_tx_en", tx_en_out, 0);
        check("async_rst_done", done, 0);
        req = '0;
        step(1);
        rst = 1'b1;
        step(1);

        // Single slot: len 5, guard 3.
        guard_len = 3;
        set_len(2, 5);
        req = 4'b0100;
        step(1);
        check("single_grant", grant, 4'b0100);
        check("single_idx", active_idx, 2);
        check("single_busy", busy, 1);
        check("single_gcount", grant_count, 1);
        seen = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen = seen & grant;
        end
        check("single_hold5", seen, 4'b0100);
        step(1);
        check("single_end_grant", grant, 0);
        check("single_end_tx", tx_en_out, 0);
        check("single_done", done, 4'b0100);
        check("single_done_ab", done_aborted, 0);
        gap = 0;
        while (!tx_en_out && gap < 20) begin
            gap++;
            step(1);
        end
        check("single_guard_gap", gap, 4);
        check("single_gcount2", grant_count, 2);
        req = '0;
        step(1);
        check("release_done", done, 4'b0100);
        check("release_done_ab", done_aborted, 0);
        wait_idle();

        // Fairness: 0,1,3 rotation, len 2, guard 0.
        pulse_reset();
        guard_len = 0;
        for (int i = 0; i < 4; i++) set_len(i, 2);
        req = 4'b1011;
        for (int k = 1; k <= 18; k++) begin
            step(1);
            s  = (k - 1) / 3;
            ph = (k - 1) % 3;
            check($sformatf("fair_grant_%0d", k), grant, (ph < 2) ? order[s % 3] : 4'b0000);
            check($sformatf("fair_tx_%0d", k), tx_en_out, (ph < 2) ? 1 : 0);
            check($sformatf("fair_done_%0d", k), done, (ph == 2) ? order[s % 3] : 4'b0000);
        end
        req = '0;
        check("fair_gcount", grant_count, 6);
        wait_idle();

        // Abort: len 100, tx_disable at slot cycle 10.
        guard_len = 2;
        set_len(1, 100);
        req = 4'b0010;
        step(10);
        check("abort_pre_grant", grant, 4'b0010);
        tx_disable = 1'b1;
        step(1);
        check("abort_tx", tx_en_out, 0);
        check("abort_grant", grant, 0);
        check("abort_done", done, 4'b0010);
        check("abort_done_ab", done_aborted, 1);
        check("abort_acount", abort_count, 1);
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen = seen | grant;
        end
        check("abort_no_grant", seen, 0);
        tx_disable = 1'b0;
        step(1);
        check("reenable_grant", grant, 4'b0010);
        check("reenable_gcount", grant_count, 8);
        req = '0;
        step(1);
        check("reenable_rel_done", done, 4'b0010);
        check("reenable_rel_ab", done_aborted, 0);
        check("reenable_acount", abort_count, 1);
        wait_idle();

        // Early release at slot cycle 7 of 50.
        set_len(0, 50);
        req = 4'b0001;
        step(7);
        check("early_grant7", grant, 4'b0001);
        req = '0;
        step(1);
        check("early_done", done, 4'b0001);
        check("early_done_ab", done_aborted, 0);
        check("early_tx", tx_en_out, 0);
        wait_idle();

        // Zero length gives exactly one slot cycle.
        set_len(3, 0);
        req = 4'b1000;
        step(1);
        check("len0_grant", grant, 4'b1000);
        step(1);
        check("len0_end", grant, 0);
        check("len0_done", done, 4'b1000);
        req = '0;
        wait_idle();

        // Release and abort together: abort wins.
        set_len(1, 20);
        req = 4'b0010;
        step(3);
        req = '0;
        tx_disable = 1'b1;
        step(1);
        check("both_done", done, 4'b0010);
        check("both_done_ab", done_aborted, 1);
        check("both_acount", abort_count, 2);
        tx_disable = 1'b0;
        wait_idle();
        check("pre_clr_gcount", grant_count, 11);

        // Counter clear, saturation, and clear-over-increment priority.
        reset_diagnostic_counter = 1'b1;
        step(1);
        reset_diagnostic_counter = 1'b0;
        check("clr_gcount", grant_count, 0);
        check("clr_acount", abort_count, 0);
        guard_len = 0;
        set_len(0, 1);
        req = 4'b0001;
        step(40);
        check("sat_gcount", grant_count, 4'hF);
        for (int i = 0; i < 4 && busy; i++) step(1);
        check("sync_idle", busy, 0);
        reset_diagnostic_counter = 1'b1;
        step(1);
        reset_diagnostic_counter = 1'b0;
        check("clr_pri_grant", grant, 4'b0001);
        check("clr_pri_gcount", grant_count, 0);
        step(2);
        check("after_clr_gcount", grant_count, 1);
        req = '0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
